seq_blink_encoder: RTL and testbench
====================================

Name: seq_blink_encoder

Overview:
Downstream consumer of the sequence generator. It accepts a 16-bit sequence value over a valid/ready handshake and converts it to BCD with a sequential double-dabble. It then shows the value on one LED as decimal pulse-count digits, most significant first, with leading zeros suppressed. All displayed durations are counted in upstream timing ticks, so the generator's speed control also scales the blink rate.

Parameters:
ON_TICKS, 4, ticks LED stays high per pulse (>=1)
OFF_TICKS, 4, ticks LED stays low after each pulse (>=1)
GAP_TICKS, 12, extra low ticks between digits (>=1)
ZERO_TICKS, 16, high ticks of the single long pulse that represents digit 0 (>=1)
CNT_W, 8, width of phase tick counter; all *_TICKS values must be < 2**CNT_W

Ports:
clk        in   1   clock
rst_n      in   1   asynchronous active-low reset
ena        in   1   global enable; when low, all state holds
tick       in   1   single-cycle timing strobe from the generator's base timer
flush      in   1   synchronous abort; returns the block to IDLE
in_valid   in   1   in_data valid
in_ready   out  1   block can accept a value
in_data    in   16  sequence value to display
led        out  1   blink output
busy       out  1   high in every state except IDLE
digit_idx  out  3   index of the digit being shown (0 = most significant shown digit)
done       out  1   one-cycle pulse when display of a value completes

Behaviour:
- Reset (async, rst_n low): state=IDLE, led=0, busy=0, done=0, digit_idx=0, BCD and counters cleared. in_ready=1 once rst_n is high.
- ena low: registers hold, done is not asserted, handshake is not accepted (in_ready=0).
- in_ready = (state==IDLE) && ena && !flush. Transfer occurs when in_valid && in_ready. in_data is latched on that edge; next state is CONVERT.
- CONVERT: 16 clk cycles, not tick-gated. Each cycle: add 3 to every BCD nibble >=5, then shift {bcd[19:0],bin[15:0]} left by 1. After 16 cycles the 5-digit BCD is exact. Max value 65535 gives 6_5_5_3_5. Next state is SKIP.
- SKIP: one cycle per leading zero digit, starting at digit 4. It stops at the first nonzero digit. If all digits are zero, it stops at digit 0, so value 0 displays a single zero digit. digit_idx resets to 0 at exit. Next state is PULSE_ON with pulse count = digit value.
- PULSE_ON: led=1. The phase counter increments on each cycle with tick=1. When count reaches ON_TICKS (ZERO_TICKS if the digit is 0), the counter clears and the next state is PULSE_OFF. led is registered and rises the cycle after entry.
- PULSE_OFF: led=0 for OFF_TICKS ticks. On expiry:
  - remaining pulses > 0: go to PULSE_ON;
  - else, more digits: go to GAP;
  - else: go to DONE.
- GAP: led=0 for GAP_TICKS ticks. Then advance to the next lower digit, increment digit_idx, and go to PULSE_ON.
- DONE: done=1 for exactly one cycle, then IDLE.
- With tick tied high, each phase lasts exactly its parameter in clk cycles. Gaps in tick stretch phases and never shorten them.
- flush (sync, highest priority after reset): next cycle state=IDLE, led=0, counters cleared, done not pulsed. flush together with in_valid in IDLE: no transfer.
- in_valid while busy is ignored. The upstream holds or drops the value; no buffering.

Optional Feature:
Macro SEQ_BLINK_BCD_OUT_EN.
- Defined: adds output port bcd_out (20 bits), holding the converted BCD of the current value. It updates at CONVERT exit, holds through display, and reads 0 after reset or flush.
- Undefined: no port and no extra logic; the BCD register is internal only.

Test Plan:
- Reset mid-PULSE_ON of value 9: rst_n low -> led=0, busy=0, in_ready=1 immediately; no done pulse.
- Value 23, tick=1, ON=2 OFF=2 GAP=4 ZERO=8. Transfer at T, then 16 CONVERT + 3 SKIP cycles. Relative to first led rise t0: led high during t0-1, t0+4-5, t0+12-13, t0+16-17, t0+20-21. digit_idx changes 0->1 at t0+12. done pulse at t0+24.
- Value 0 -> one high pulse of 8 cycles, OFF 2 cycles, done. Value 105 -> 1 pulse, gap, 8-cycle long pulse, gap, 5 pulses.
- Value 65535 -> digits 6,5,5,3,5 observed as pulse counts. bcd_out=0x65535 when SEQ_BLINK_BCD_OUT_EN is defined.
- tick asserted every 3rd cycle -> each phase length is tripled; pulse counts are unchanged.
- flush during GAP of value 47 -> led=0 and state IDLE next cycle; no done pulse. A new value 3 is accepted on the next valid and shows 3 pulses.

Source files
------------

// File: rtl/seq_blink_encoder.sv
// Latches a 16-bit value, converts it to BCD with a sequential double-dabble and blinks it
// on one LED as decimal pulse-count digits. Define SEQ_BLINK_BCD_OUT_EN to expose bcd_out.
module seq_blink_encoder #(
    parameter int ON_TICKS   = 4,
    parameter int OFF_TICKS  = 4,
    parameter int GAP_TICKS  = 12,
    parameter int ZERO_TICKS = 16,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        tick,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        led,
    output logic        busy,
    output logic [2:0]  digit_idx,
    output logic        done
`ifdef SEQ_BLINK_BCD_OUT_EN
    ,
    output logic [19:0] bcd_out
`endif
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CONVERT   = 3'd1;
    localparam logic [2:0] SKIP      = 3'd2;
    localparam logic [2:0] PULSE_ON  = 3'd3;
    localparam logic [2:0] PULSE_OFF = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]       state;
    logic [15:0]      bin;
    logic [19:0]      bcd, bcd_adj, bcd_shift;
    logic [3:0]       conv_cnt;
    logic [2:0]       sel, sel_dn;
    logic [3:0]       pulses, cur_dig, nxt_dig;
    logic [CNT_W-1:0] ph_cnt, ph_inc, limit;
    logic             ph_exp;

    function automatic logic [3:0] digit_at(input logic [19:0] b, input logic [2:0] s);
        case (s)
            3'd0:    digit_at = b[3:0];
            3'd1:    digit_at = b[7:4];
            3'd2:    digit_at = b[11:8];
            3'd3:    digit_at = b[15:12];
            3'd4:    digit_at = b[19:16];
            default: digit_at = 4'd0;
        endcase
    endfunction

    assign in_ready = (state == IDLE) && ena && !flush;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE) && ena && !flush;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    assign bcd_shift = {bcd_adj[18:0], bin[15]};

    assign sel_dn  = sel - 3'd1;
    assign cur_dig = digit_at(bcd, sel);
    assign nxt_dig = digit_at(bcd, sel_dn);

    // A zero digit is shown as one long pulse instead of no pulse at all.
    always_comb begin
        case (state)
            PULSE_ON:  limit = (cur_dig == 4'd0) ? CNT_W'(ZERO_TICKS) : CNT_W'(ON_TICKS);
            PULSE_OFF: limit = CNT_W'(OFF_TICKS);
            default:   limit = CNT_W'(GAP_TICKS);
        endcase
    end
    assign ph_inc = ph_cnt + 1'b1;
    assign ph_exp = tick && (ph_inc == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            conv_cnt  <= '0;
            sel       <= '0;
            pulses    <= '0;
            ph_cnt    <= '0;
            led       <= 1'b0;
            digit_idx <= '0;
        end else if (flush) begin
            state     <= IDLE;
            conv_cnt  <= '0;
            sel       <= '0;
            pulses    <= '0;
            ph_cnt    <= '0;
            led       <= 1'b0;
            digit_idx <= '0;
        end else if (ena) begin
            case (state)
                IDLE: if (in_valid) begin
                    bin      <= in_data;
                    bcd      <= '0;
                    conv_cnt <= '0;
                    state    <= CONVERT;
                end
                CONVERT: begin
                    bcd      <= bcd_shift;
                    bin      <= {bin[14:0], 1'b0};
                    conv_cnt <= conv_cnt + 4'd1;
                    if (conv_cnt == 4'd15) begin
                        sel   <= 3'd4;
                        state <= SKIP;
                    end
                end
                // Looks one digit ahead so each leading zero costs exactly one cycle.
                SKIP: begin
                    if (cur_dig != 4'd0 || sel == 3'd0) begin
                        pulses    <= cur_dig;
                        digit_idx <= '0;
                        ph_cnt    <= '0;
                        led       <= 1'b1;
                        state     <= PULSE_ON;
                    end else begin
                        sel <= sel_dn;
                        if (nxt_dig != 4'd0 || sel_dn == 3'd0) begin
                            pulses    <= nxt_dig;
                            digit_idx <= '0;
                            ph_cnt    <= '0;
                            led       <= 1'b1;
                            state     <= PULSE_ON;
                        end
                    end
                end
                PULSE_ON: begin
                    if (tick) ph_cnt <= ph_exp ? '0 : ph_inc;
                    if (ph_exp) begin
                        led   <= 1'b0;
                        state <= PULSE_OFF;
                        if (pulses != 4'd0) pulses <= pulses - 4'd1;
                    end
                end
                PULSE_OFF: begin
                    if (tick) ph_cnt <= ph_exp ? '0 : ph_inc;
                    if (ph_exp) begin
                        if (pulses != 4'd0) begin
                            led   <= 1'b1;
                            state <= PULSE_ON;
                        end else if (sel != 3'd0) begin
                            state <= GAP;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                GAP: begin
                    if (tick) ph_cnt <= ph_exp ? '0 : ph_inc;
                    if (ph_exp) begin
                        sel       <= sel_dn;
                        digit_idx <= digit_idx + 3'd1;
                        pulses    <= nxt_dig;
                        led       <= 1'b1;
                        state     <= PULSE_ON;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_BLINK_BCD_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bcd_out <= '0;
        else if (flush)
            bcd_out <= '0;
        else if (ena && state == CONVERT && conv_cnt == 4'd15)
            bcd_out <= bcd_shift;
    end
`endif

endmodule

// File: tb/tb_seq_blink_encoder.sv
// Randomized bench for seq_blink_encoder: a decimal pulse-train model predicts the LED,
// digit_idx and done timing from ticks actually delivered.
module tb_seq_blink_encoder;
    localparam int ON = 2, OFF = 2, GAP = 4, ZERO = 8;

    logic        clk, rst_n, ena, tick, flush, in_valid, in_ready, led, busy, done;
    logic [15:0] in_data;
    logic [2:0]  digit_idx;
`ifdef SEQ_BLINK_BCD_OUT_EN
    logic [19:0] bcd_out;
`endif

    int checks = 0, errors = 0, cyc = 0;
    int tick_mode = 1;
    bit ena_rand = 0;

    typedef struct { bit lvl; int rem; int idx; } phase_t;
    phase_t q[$];

    seq_blink_encoder #(.ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP),
                        .ZERO_TICKS(ZERO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .led(led),
        .busy(busy), .digit_idx(digit_idx), .done(done)
`ifdef SEQ_BLINK_BCD_OUT_EN
        , .bcd_out(bcd_out)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Display as a list of (level, tick count, digit index) phases, from decimal digits.
    function automatic void build_model(input int v);
        int d[5];
        int x, first, n;
        q.delete();
        x = v;
        for (int i = 0; i < 5; i++) begin d[i] = x % 10; x = x / 10; end
        first = 0;
        for (int i = 4; i >= 0; i--) if (d[i] != 0) begin first = i; break; end
        n = 0;
        for (int i = first; i >= 0; i--) begin
            if (d[i] == 0) begin
                q.push_back('{1'b1, ZERO, n});
                q.push_back('{1'b0, OFF, n});
            end else begin
                for (int p = 0; p < d[i]; p++) begin
                    q.push_back('{1'b1, ON, n});
                    q.push_back('{1'b0, OFF, n});
                end
            end
            if (i != 0) q.push_back('{1'b0, GAP, n});
            n++;
        end
    endfunction

    task automatic tick_step();
        @(posedge clk); #1;
        case (tick_mode)
            1:       tick = 1'b1;
            3:       tick = (cyc % 3 == 0);
            default: tick = 1'($urandom_range(0, 1));
        endcase
        ena = ena_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic send(input logic [15:0] v, output int xfer);
        xfer = -1;
        for (int k = 0; k < 200; k++) begin
            tick_step(); in_valid = 1'b1; in_data = v;
            @(negedge clk);
            if (in_ready === 1'b1) begin xfer = cyc; break; end
        end
        checks++;
        if (xfer < 0) begin errors++; $display("FAIL send %0d: in_ready never seen, required 1", v); end
    endtask

    task automatic wait_rise(input string name, output int t0);
        int pre_bad;
        pre_bad = 0; t0 = -1;
        for (int k = 0; k < 600; k++) begin
            tick_step(); in_valid = 1'b0;
            @(negedge clk);
            if (led === 1'b1) begin t0 = cyc; break; end
            if (done !== 1'b0 || busy !== 1'b1) pre_bad++;
        end
        checks++;
        if (t0 < 0) begin errors++; $display("FAIL %s first_led: no rise seen, required a rise", name); end
        checks++;
        if (pre_bad !== 0) begin errors++; $display("FAIL %s pre_led_ctl: %0d bad cycles, required 0", name, pre_bad); end
    endtask

    task automatic check_display(input string name, output int done_cyc);
        phase_t cur;
        int led_bad, idx_bad, ctl_bad, first_bad, start;
        bit fin, found;
        led_bad = 0; idx_bad = 0; ctl_bad = 0; first_bad = -1; fin = 0; found = 0;
        start = cyc; done_cyc = -1;
        cur = q.pop_front();
        for (int k = 0; k < 3000 && !fin; k++) begin
            if (led !== cur.lvl) begin led_bad++; if (first_bad < 0) first_bad = cyc - start; end
            if (digit_idx !== 3'(cur.idx)) idx_bad++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) ctl_bad++;
            if (ena && tick) begin
                cur.rem--;
                if (cur.rem == 0) begin
                    if (q.size() == 0) fin = 1;
                    else cur = q.pop_front();
                end
            end
            tick_step();
            in_valid = fin ? 1'b0 : 1'($urandom & 1);
            in_data = 16'($urandom);
            @(negedge clk);
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL %s finish: display model never finished, required finish", name); return; end
        // Display ended: done must appear on the first enabled cycle, LED low meanwhile.
        for (int k = 0; k < 50; k++) begin
            if (ena === 1'b1) begin found = 1; break; end
            if (done !== 1'b0 || led !== 1'b0) ctl_bad++;
            tick_step(); in_valid = 1'b0;
            @(negedge clk);
        end
        done_cyc = cyc;
        checks++;
        if (!found || done !== 1'b1 || led !== 1'b0)
            begin errors++; $display("FAIL %s done: done=%b led=%b, required done=1 led=0", name, done, led); end
        tick_step(); in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL %s idle_after: busy=%b done=%b, required 0 0", name, busy, done); end
        checks++;
        if (led_bad !== 0) begin errors++; $display("FAIL %s led: %0d bad cycles (first at t0+%0d), required 0", name, led_bad, first_bad); end
        checks++;
        if (idx_bad !== 0) begin errors++; $display("FAIL %s digit_idx: %0d bad cycles, required 0", name, idx_bad); end
        checks++;
        if (ctl_bad !== 0) begin errors++; $display("FAIL %s busy/ready/done: %0d bad cycles, required 0", name, ctl_bad); end
    endtask

    task automatic run_value(input logic [15:0] v, input string name, output int t0, output int dc, output int xfer);
        build_model(int'(v));
        send(v, xfer);
        wait_rise(name, t0);
        if (t0 >= 0) check_display(name, dc);
        else dc = -1;
    endtask

    task automatic test_reset();
        int x, t0, bad;
        rst_n = 1'b0; ena = 1'b1; tick = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({led, busy, done} !== 3'b000) begin errors++; $display("FAIL reset outs: led/busy/done=%b, required 000", {led, busy, done}); end
        checks++;
        if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset digit_idx: %0d, required 0", digit_idx); end
`ifdef SEQ_BLINK_BCD_OUT_EN
        checks++;
        if (bcd_out !== 20'h0) begin errors++; $display("FAIL reset bcd_out: %h, required 0", bcd_out); end
`endif
        tick_step(); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: %b, required 1", in_ready); end
        send(16'd9, x);
        wait_rise("reset9", t0);
        tick_step(); #1 rst_n = 1'b0; #1;
        checks++;
        if (led !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL midreset: led=%b busy=%b ready=%b done=%b, required 0 0 1 0", led, busy, in_ready, done); end
        tick_step(); tick_step(); rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick_step();
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || led !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL post_reset_idle: %0d bad cycles, required 0", bad); end
    endtask

    task automatic test_value_23();
        int t0, dc, xfer;
        tick_mode = 1; ena_rand = 0;
        run_value(16'd23, "v23", t0, dc, xfer);
        checks++;
        if (t0 - xfer !== 20) begin errors++; $display("FAIL v23 latency: %0d, required 20", t0 - xfer); end
        checks++;
        if (dc - t0 !== 24) begin errors++; $display("FAIL v23 done_time: t0+%0d, required t0+24", dc - t0); end
    endtask

    task automatic test_zero_and_105();
        int t0, dc, xfer;
        tick_mode = 1; ena_rand = 0;
        run_value(16'd0, "v0", t0, dc, xfer);
        checks++;
        if (dc - t0 !== 10) begin errors++; $display("FAIL v0 done_time: t0+%0d, required t0+10", dc - t0); end
        run_value(16'd105, "v105", t0, dc, xfer);
        checks++;
        if (dc - t0 !== 42) begin errors++; $display("FAIL v105 done_time: t0+%0d, required t0+42", dc - t0); end
    endtask

    task automatic test_max();
        int t0, dc, xfer;
        tick_mode = 1; ena_rand = 0;
        build_model(65535);
        send(16'hFFFF, xfer);
        wait_rise("vmax", t0);
`ifdef SEQ_BLINK_BCD_OUT_EN
        checks++;
        if (bcd_out !== 20'h65535) begin errors++; $display("FAIL vmax bcd_out: %h, required 65535", bcd_out); end
`endif
        if (t0 >= 0) check_display("vmax", dc);
        checks++;
        if (dc - t0 !== 112) begin errors++; $display("FAIL vmax done_time: t0+%0d, required t0+112", dc - t0); end
    endtask

    task automatic test_slow_tick();
        int t0, dc, xfer;
        tick_mode = 3; ena_rand = 0;
        run_value(16'd23, "slow23", t0, dc, xfer);
        run_value(16'($urandom_range(1000, 9999)), "slow_rand", t0, dc, xfer);
    endtask

    task automatic test_random();
        int t0, dc, xfer;
        logic [15:0] v;
        tick_mode = 0; ena_rand = 1;
        for (int k = 0; k < 6; k++) begin
            case (k % 3)
                0:       v = 16'($urandom_range(0, 99));
                1:       v = 16'($urandom_range(100, 9999));
                default: v = 16'($urandom_range(10000, 65535));
            endcase
            run_value(v, $sformatf("rand%0d_%0d", k, v), t0, dc, xfer);
        end
        ena_rand = 0;
    endtask

    task automatic test_flush();
        int t0, dc, xfer, bad;
        tick_mode = 1; ena_rand = 0;
        send(16'd47, xfer);
        wait_rise("flush47", t0);
        while (cyc < t0 + 16) begin tick_step(); in_valid = 1'b0; @(negedge clk); end
        checks++;
        if (led !== 1'b0 || busy !== 1'b1 || digit_idx !== 3'd0)
            begin errors++; $display("FAIL flush in_gap: led=%b busy=%b idx=%0d, required 0 1 0", led, busy, digit_idx); end
        tick_step(); flush = 1'b1; in_valid = 1'b1; in_data = 16'd5;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush cycle: done=%b ready=%b, required 0 0", done, in_ready); end
        tick_step(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || led !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush after: busy=%b led=%b ready=%b, required 0 0 1", busy, led, in_ready); end
`ifdef SEQ_BLINK_BCD_OUT_EN
        checks++;
        if (bcd_out !== 20'h0) begin errors++; $display("FAIL flush bcd_out: %h, required 0", bcd_out); end
`endif
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick_step(); @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || led !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL flush quiet: %0d bad cycles, required 0", bad); end
        tick_step(); flush = 1'b1; in_valid = 1'b1; in_data = 16'd7;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_idle ready: %b, required 0", in_ready); end
        tick_step(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle busy: %b, required 0", busy); end
        run_value(16'd3, "after_flush3", t0, dc, xfer);
    endtask

    initial begin
        test_reset();
        test_value_23();
        test_zero_and_105();
        test_max();
        test_slow_tick();
        test_random();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
